// File: rtl/enc_period_avg.sv
// Encoder period averager: captures settled edge-to-edge periods into an N-deep moving average.
// Result SETTLE+2 cycles after edge_stb; edges arriving mid-capture restart the settle window and count a drop.
module enc_period_avg #(
  parameter int LOG2N  = 2,
  parameter int SETTLE = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] period_in,
  input  logic        edge_stb,
  output logic [21:0] avg_period,
  output logic [21:0] period_out,
  output logic        avg_dir,
  output logic        avg_valid,
  output logic        avg_stb,
  output logic        ovf,
  output logic [7:0]  drop_cnt
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = 22 + LOG2N;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [21:0]  OVF_VAL = 22'h3FFFFF;
  localparam logic [LOG2N:0] FULL  = (LOG2N + 1)'(N);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_UPDATE} state_t;
  // With a one-cycle settle the capture happens directly after the edge.
  localparam state_t ST_ENTRY = (SETTLE <= 1) ? ST_CAPTURE : ST_SETTLE;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic            pend;
  logic [21:0]     sample;
  logic            s_latched, s_dir, s_dchg;
  logic [LOG2N:0]  fill;
  logic [SW-1:0]   sum;
  logic [LOG2N-1:0] wr_ptr;
  logic [21:0]     ring [N];

  logic            is_ovf, flush, full, wr_en, nx_valid;
  logic [LOG2N:0]  base_fill, nx_fill;
  logic [SW-1:0]   base_sum, nx_sum;
  logic [LOG2N-1:0] base_ptr, nx_ptr;
  logic [21:0]     nx_avg;
  logic            unused_bits;

  assign unused_bits = ^period_in[28:22];

  always_comb begin
    is_ovf    = (sample == OVF_VAL);
    flush     = s_dchg || ((fill != '0) && (s_dir != avg_dir)) || is_ovf;
    base_fill = flush ? '0 : fill;
    base_sum  = flush ? '0 : sum;
    base_ptr  = flush ? '0 : wr_ptr;
    full      = (base_fill == FULL);
    nx_fill   = '0;
    nx_sum    = '0;
    nx_ptr    = '0;
    if (!is_ovf) begin
      if (full) begin
        nx_sum  = base_sum + SW'(sample) - SW'(ring[base_ptr]);
        nx_fill = base_fill;
      end else begin
        nx_sum  = base_sum + SW'(sample);
        nx_fill = base_fill + 1'b1;
      end
      nx_ptr = base_ptr + 1'b1;
    end
    nx_valid = (nx_fill == FULL);
    nx_avg   = nx_valid ? 22'(nx_sum >> LOG2N) : sample;
    wr_en    = (state == ST_UPDATE) && s_latched && !is_ovf;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ring[base_ptr] <= sample;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      pend       <= 1'b0;
      sample     <= '0;
      s_latched  <= 1'b0;
      s_dir      <= 1'b0;
      s_dchg     <= 1'b0;
      fill       <= '0;
      sum        <= '0;
      wr_ptr     <= '0;
      avg_period <= '0;
      period_out <= '0;
      avg_dir    <= 1'b0;
      avg_valid  <= 1'b0;
      avg_stb    <= 1'b0;
      ovf        <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      avg_stb <= 1'b0;
      // Live free-running count wins once it exceeds the average: the encoder is slowing.
      if (avg_valid && !period_in[31] && !period_in[29] && (period_in[21:0] > avg_period))
        period_out <= period_in[21:0];
      else
        period_out <= avg_period;

      case (state)
        ST_IDLE: begin
          if (edge_stb || pend) begin
            pend       <= 1'b0;
            settle_cnt <= CW'(SETTLE);
            state      <= ST_ENTRY;
          end
        end
        ST_SETTLE: begin
          if (edge_stb) begin
            settle_cnt <= CW'(SETTLE);
            state      <= ST_ENTRY;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
            if (int'(settle_cnt) <= 2) state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (edge_stb) begin
            settle_cnt <= CW'(SETTLE);
            state      <= ST_ENTRY;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end else begin
            sample    <= period_in[21:0];
            s_latched <= period_in[31];
            s_dir     <= period_in[30];
            s_dchg    <= period_in[29];
            state     <= ST_UPDATE;
          end
        end
        default: begin
          if (edge_stb) pend <= 1'b1;
          avg_stb <= 1'b1;
          if (s_latched) begin
            fill       <= nx_fill;
            sum        <= nx_sum;
            wr_ptr     <= nx_ptr;
            avg_dir    <= s_dir;
            ovf        <= is_ovf;
            avg_valid  <= nx_valid;
            avg_period <= nx_avg;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_period_avg.sv
// Directed bench for enc_period_avg: expected results queued at issue, checked by a monitor on avg_stb.
module tb_enc_period_avg;
  localparam int SETTLE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] period_in;
  logic        edge_stb;
  logic [21:0] avg_period, period_out;
  logic        avg_dir, avg_valid, avg_stb, ovf;
  logic [7:0]  drop_cnt;

  enc_period_avg #(.LOG2N(2), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .period_in(period_in), .edge_stb(edge_stb),
    .avg_period(avg_period), .period_out(period_out), .avg_dir(avg_dir),
    .avg_valid(avg_valid), .avg_stb(avg_stb), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] per;
    logic        vld;
    logic        dir;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int last_stb_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && avg_stb) begin
      stb_cnt++;
      last_stb_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_stb: got avg_stb at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("avg_period", 32'(avg_period), 32'(e.per));
        check("avg_valid", 32'(avg_valid), 32'(e.vld));
        check("avg_dir", 32'(avg_dir), 32'(e.dir));
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  function automatic logic [31:0] mk(input logic lat, input logic dir, input logic dchg,
                                     input logic [21:0] cnt);
    return {lat, dir, dchg, 2'b00, 2'b00, 3'b000, cnt};
  endfunction

  task automatic expect_out(input logic [21:0] per, input logic vld, input logic dir, input logic ov);
    exp_t e;
    e.per = per; e.vld = vld; e.dir = dir; e.ovf = ov;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [31:0] w);
    period_in = w;
    edge_stb  = 1'b1;
    @(posedge clk); #1;
    edge_stb  = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic [21:0] per, input logic vld,
                      input logic dir, input logic ov);
    expect_out(per, vld, dir, ov);
    pulse(w);
    repeat (SETTLE + 2) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int s;
    int stb0;
    reset     = 1'b1;
    edge_stb  = 1'b0;
    period_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_avg_period", 32'(avg_period), 0);
    check("rst_period_out", 32'(period_out), 0);
    check("rst_avg_valid", 32'(avg_valid), 0);
    check("rst_avg_dir", 32'(avg_dir), 0);
    check("rst_avg_stb", 32'(avg_stb), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Steady motion, first edge also checks edge-to-strobe latency.
    expect_out(22'd1000, 1'b0, 1'b0, 1'b0);
    pulse(mk(1, 0, 0, 22'd1000));
    s = cyc;
    repeat (SETTLE + 2) @(posedge clk);
    #1;
    check("stb_latency", 32'(last_stb_cyc), 32'(s + SETTLE + 1));
    send(mk(1, 0, 0, 22'd1000), 22'd1000, 1'b0, 1'b0, 1'b0);
    send(mk(1, 0, 0, 22'd1000), 22'd1000, 1'b0, 1'b0, 1'b0);
    send(mk(1, 0, 0, 22'd1000), 22'd1000, 1'b1, 1'b0, 1'b0);
    send(mk(1, 0, 0, 22'd2000), 22'd1250, 1'b1, 1'b0, 1'b0);

    // Reversal flag, then a silent direction mismatch.
    send(mk(1, 1, 1, 22'd800),  22'd800, 1'b0, 1'b1, 1'b0);
    send(mk(1, 1, 0, 22'd600),  22'd600, 1'b0, 1'b1, 1'b0);
    send(mk(1, 0, 0, 22'd700),  22'd700, 1'b0, 1'b0, 1'b0);

    // Overflow, recovery, and a rejected free-running sample.
    send(mk(1, 0, 0, 22'h3FFFFF), 22'h3FFFFF, 1'b0, 1'b0, 1'b1);
    send(mk(1, 1, 0, 22'd500),  22'd500, 1'b0, 1'b1, 1'b0);
    send(mk(0, 1, 0, 22'd999),  22'd500, 1'b0, 1'b1, 1'b0);

    // Refill: 500+900+1100+1500 = 4000 -> 1000; replace 500 by 1003 -> 4503>>2 = 1125.
    send(mk(1, 1, 0, 22'd900),  22'd900,  1'b0, 1'b1, 1'b0);
    send(mk(1, 1, 0, 22'd1100), 22'd1100, 1'b0, 1'b1, 1'b0);
    send(mk(1, 1, 0, 22'd1500), 22'd1000, 1'b1, 1'b1, 1'b0);
    send(mk(1, 1, 0, 22'd1003), 22'd1125, 1'b1, 1'b1, 1'b0);

    // Slowdown: period_out follows only a qualified live count above the average.
    period_in = mk(0, 1, 0, 22'd1500);
    repeat (2) @(posedge clk);
    #1;
    check("slow_period_out", 32'(period_out), 1500);
    check("slow_avg_period", 32'(avg_period), 1125);
    check("slow_avg_valid", 32'(avg_valid), 1);
    period_in = mk(0, 1, 0, 22'd1100);
    repeat (2) @(posedge clk);
    #1;
    check("slow_below_avg", 32'(period_out), 1125);
    period_in = mk(1, 1, 0, 22'd1500);
    repeat (2) @(posedge clk);
    #1;
    check("slow_latched", 32'(period_out), 1125);
    period_in = mk(0, 1, 1, 22'd1500);
    repeat (2) @(posedge clk);
    #1;
    check("slow_dchg", 32'(period_out), 1125);

    // Re-trigger two cycles in: one drop, one strobe; 4503+1125-900 = 4728 -> 1182.
    stb0 = stb_cnt;
    expect_out(22'd1182, 1'b1, 1'b1, 1'b0);
    pulse(mk(1, 1, 0, 22'd1125));
    s = cyc;
    @(posedge clk); #1;
    pulse(mk(1, 1, 0, 22'd1125));
    repeat (8) @(posedge clk);
    #1;
    check("retrig_drop_cnt", 32'(drop_cnt), 1);
    check("retrig_stb_count", 32'(stb_cnt - stb0), 1);
    check("retrig_stb_cycle", 32'(last_stb_cyc), 32'(s + 2 + SETTLE + 1));

    // Reset while settling.
    pulse(mk(1, 1, 0, 22'd2000));
    @(posedge clk); #1;
    stb0  = stb_cnt;
    reset = 1'b1;
    #1;
    check("mid_rst_avg_period", 32'(avg_period), 0);
    check("mid_rst_period_out", 32'(period_out), 0);
    check("mid_rst_avg_valid", 32'(avg_valid), 0);
    check("mid_rst_avg_dir", 32'(avg_dir), 0);
    check("mid_rst_ovf", 32'(ovf), 0);
    check("mid_rst_drop_cnt", 32'(drop_cnt), 0);
    check("mid_rst_avg_stb", 32'(avg_stb), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_stb", 32'(stb_cnt - stb0), 0);
    send(mk(1, 0, 0, 22'd300), 22'd300, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
